// File: rtl/alarm_scan_mux.sv
// N-channel alarm selector/scanner: sticky per-channel pending flags, presented
// on alarm either by manual select or by a round-robin scan that halts on alarms.
module alarm_scan_mux #(
  parameter int N     = 8,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     i,
  input  logic [SEL_W-1:0] sel,
  input  logic             scan,
  input  logic             ack,
  output logic             alarm,
  output logic [SEL_W-1:0] ch,
  output logic [N-1:0]     pending,
  output logic             any
);

  localparam int DCNT_W = $clog2(DWELL + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    MANUAL,
    RUN,
    HOLD
  } state_t;

  state_t            state, state_d;
  logic [N-1:0]      i_q;
  logic [N-1:0]      pending_d;
  logic [SEL_W-1:0]  ch_d;
  logic [DCNT_W-1:0] dcnt, dcnt_d;

  // Single capture stage for the raw alarm levels; no further synchronisation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q     <= '0;
      pending <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      i_q     <= i;
      pending <= pending_d;
    end
  end

  // Clear is applied first and the set OR-ed in afterwards, so an acknowledge
  // of a still-active input leaves the channel pending.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    pending_d = pending;
    if (ack) pending_d[ch] = 1'b0;
    pending_d = pending_d | i_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MANUAL;
      ch    <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_d;
      ch    <= ch_d;
      dcnt  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state;
    if (!scan) begin
      state_d = MANUAL;
    end else begin
      case (state)
        MANUAL:  state_d = RUN;
        RUN:     if (pending[ch]) state_d = HOLD;
        HOLD:    if (!pending[ch]) state_d = RUN;
        default: state_d = MANUAL;
      endcase
    end
  end

  // A pending channel wins over dwell expiry, so the scan never skips it.
  always_comb begin
    ch_d   = ch;
    dcnt_d = '0;
    if (!scan) begin
      ch_d = sel;
    end else begin
      case (state)
        RUN: begin
          if (!pending[ch]) begin
            if (dcnt == DCNT_LAST) ch_d = ch + SEL_W'(1);
            else                   dcnt_d = dcnt + DCNT_W'(1);
          end
        end
        HOLD:    if (!pending[ch]) ch_d = ch + SEL_W'(1);
        default: ;
      endcase
    end
  end

  assign alarm = pending[ch];
  assign any   = |pending;

endmodule

// File: tb/tb_alarm_scan_mux.sv
// Directed bench for alarm_scan_mux (N=8, DWELL=4): a per-cycle vector table for
// manual mode plus hand-written scan, halt, wrap and reset sequences.
module tb_alarm_scan_mux;

  logic       clk;
  logic       reset;
  logic [7:0] i;
  logic [2:0] sel;
  logic       scan;
  logic       ack;
  logic       alarm;
  logic [2:0] ch;
  logic [7:0] pending;
  logic       any;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_scan_mux #(.N(8), .SEL_W(3), .DWELL(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .i       (i),
    .sel     (sel),
    .scan    (scan),
    .ack     (ack),
    .alarm   (alarm),
    .ch      (ch),
    .pending (pending),
    .any     (any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       scan;
    logic [2:0] sel;
    logic [7:0] i;
    logic       ack;
    logic [2:0] ch;
    logic [7:0] pend;
    logic       alarm;
    logic       any;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    i = '0; sel = '0; scan = 1'b0; ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ch(input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while (ch !== target && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("reach ch%0d", target), 32'(ch), 32'(target));
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    // scan sel  i      ack   ch    pend   alarm any
    tbl[0]  = '{1'b0, 3'd5, 8'h00, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 3'd5, 8'h20, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 3'd5, 8'h00, 1'b0, 3'd5, 8'h20, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 3'd5, 8'h00, 1'b0, 3'd5, 8'h20, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 3'd5, 8'h00, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'd2, 8'h00, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'd2, 8'h04, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 3'd2, 8'h04, 1'b1, 3'd2, 8'h04, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 3'd2, 8'h00, 1'b1, 3'd2, 8'h04, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 3'd2, 8'h00, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 3'd3, 8'h00, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 3'd3, 8'h41, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 3'd3, 8'h00, 1'b1, 3'd3, 8'h41, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 3'd3, 8'h00, 1'b1, 3'd3, 8'h41, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h41, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h40, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 3'd6, 8'h00, 1'b0, 3'd6, 8'h40, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 3'd6, 8'h00, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0};

    // Reset state
    apply_reset();
    check("reset ch", 32'(ch), 32'd0);
    check("reset pending", 32'(pending), 32'h00);
    check("reset alarm", 32'(alarm), 32'd0);
    check("reset any", 32'(any), 32'd0);

    // Manual mode vectors, one edge per row
    for (int r = 0; r < 18; r++) begin
      scan = tbl[r].scan; sel = tbl[r].sel; i = tbl[r].i; ack = tbl[r].ack;
      tick();
      check($sformatf("vec%0d ch", r), 32'(ch), 32'(tbl[r].ch));
      check($sformatf("vec%0d pending", r), 32'(pending), 32'(tbl[r].pend));
      check($sformatf("vec%0d alarm", r), 32'(alarm), 32'(tbl[r].alarm));
      check($sformatf("vec%0d any", r), 32'(any), 32'(tbl[r].any));
    end
    ack = 1'b0;

    // Idle scan: each channel shown for 4 cycles, wrapping 7 -> 0
    apply_reset();
    scan = 1'b1;
    for (int t = 1; t <= 64; t++) begin
      tick();
      check($sformatf("scan t%0d ch", t), 32'(ch), 32'(((t - 1) / 4) % 8));
      check($sformatf("scan t%0d alarm", t), 32'(alarm), 32'd0);
      check($sformatf("scan t%0d any", t), 32'(any), 32'd0);
    end

    // Scan halt on channel 3
    wait_ch(3'd3, 40);
    i = 8'h08;
    tick();
    i = 8'h00;
    tick();
    check("halt pending", 32'(pending), 32'h08);
    check("halt alarm", 32'(alarm), 32'd1);
    for (int t = 0; t < 24; t++) begin
      tick();
      check($sformatf("halt hold%0d ch", t), 32'(ch), 32'd3);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("halt ack pending", 32'(pending), 32'h00);
    check("halt ack alarm", 32'(alarm), 32'd0);
    check("halt ack ch", 32'(ch), 32'd3);
    tick();
    check("halt resume ch", 32'(ch), 32'd4);

    // Set beats clear while holding on channel 3
    wait_ch(3'd3, 40);
    i = 8'h08;
    tick(); tick(); tick();
    check("sbc hold ch", 32'(ch), 32'd3);
    pulse_ack();
    tick();
    check("sbc pending", 32'(pending), 32'h08);
    check("sbc ch", 32'(ch), 32'd3);
    tick(); tick();
    check("sbc still ch", 32'(ch), 32'd3);
    i = 8'h00;
    tick(); tick();
    check("sbc drop pending", 32'(pending), 32'h08);
    pulse_ack();
    check("sbc clear pending", 32'(pending), 32'h00);
    tick();
    check("sbc resume ch", 32'(ch), 32'd4);

    // Wrap and simultaneous alarms on channels 0 and 7
    wait_ch(3'd5, 40);
    i = 8'h81;
    tick();
    i = 8'h00;
    tick();
    check("wrap pending", 32'(pending), 32'h81);
    wait_ch(3'd7, 40);
    tick(); tick(); tick(); tick(); tick();
    check("wrap halt7 ch", 32'(ch), 32'd7);
    check("wrap halt7 alarm", 32'(alarm), 32'd1);
    pulse_ack();
    check("wrap ack7 pending", 32'(pending), 32'h01);
    tick();
    check("wrap to0 ch", 32'(ch), 32'd0);
    check("wrap to0 alarm", 32'(alarm), 32'd1);
    tick(); tick(); tick(); tick(); tick();
    check("wrap halt0 ch", 32'(ch), 32'd0);
    pulse_ack();
    check("wrap ack0 pending", 32'(pending), 32'h00);
    tick();
    check("wrap resume ch", 32'(ch), 32'd1);

    // Asynchronous reset in the middle of HOLD with two alarms pending
    i = 8'h81;
    tick();
    i = 8'h00;
    wait_ch(3'd7, 40);
    tick(); tick();
    check("prerst pending", 32'(pending), 32'h81);
    check("prerst ch", 32'(ch), 32'd7);
    sel = 3'd6;
    #2 reset = 1'b1;
    #1;
    check("rst ch", 32'(ch), 32'd0);
    check("rst pending", 32'(pending), 32'h00);
    check("rst alarm", 32'(alarm), 32'd0);
    check("rst any", 32'(any), 32'd0);
    tick();
    reset = 1'b0;
    // From MANUAL with scan held high the first edge enters RUN without taking sel.
    for (int t = 1; t <= 5; t++) begin
      tick();
      check($sformatf("postrst t%0d ch", t), 32'(ch), (t == 5) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_scan_mux.md
# alarm_scan_mux

Parametrised N-channel alarm selector/scanner, the sequential successor to the lab's 8:1 alarm multiplexer. It captures raw alarm inputs into sticky per-channel pending flags and presents one channel on ALARM. The channel is chosen either manually by SEL or by an automatic round-robin scan that halts on a pending alarm until it is acknowledged. It sits between the alarm sensor inputs and the panel indicator/acknowledge logic.

## Interface
- N, 8: channel count, power of two, 2..64
- SEL_W, 3: channel index width, equal to log2(N)
- DWELL, 4: cycles spent on each channel in scan mode, 1..255
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-high reset
- I  in  N  raw alarm inputs, asynchronous levels
- SEL  in  SEL_W  manual channel select
- SCAN  in  1  mode: 0 = manual, 1 = auto-scan
- ACK  in  1  acknowledge for channel CH, sampled each edge
- ALARM  out  1  PENDING[CH]
- CH  out  SEL_W  currently presented channel (registered)
- PENDING  out  N  sticky alarm flags (registered)
- ANY  out  1  OR of PENDING

## Operation
- Input stage: I is registered once into I_Q. There is no further synchronisation.
- Pending latch, per channel k, each edge:
  - Set when I_Q[k]=1.
  - Cleared when ACK=1, CH=k and I_Q[k]=0.
  - Set beats clear: acknowledging a still-active input leaves it pending.
  - ACK never affects channels other than CH.
- FSM states: MANUAL, RUN, HOLD. A dwell counter DCNT has width ceil(log2(DWELL+1)).
  - MANUAL:
    - CH <= SEL every cycle; DCNT=0.
    - SCAN=1 -> RUN. CH keeps its last value and DCNT=0.
  - RUN:
    - If PENDING[CH]=1 -> HOLD; CH frozen, DCNT=0.
    - Else if DCNT=DWELL-1: CH <= CH+1 modulo N (N-1 wraps to 0) and DCNT<=0.
    - Else DCNT<=DCNT+1.
    - A pending channel beats dwell expiry in the same cycle: no advance.
  - HOLD:
    - CH frozen.
    - When PENDING[CH]=0 -> RUN with CH <= CH+1 modulo N and DCNT=0.
  - SCAN=0 in any state -> MANUAL at the next edge, with CH <= SEL on that edge.
- ALARM = PENDING[CH]; ANY = |PENDING. Both are combinational from registers only, so there is no input-to-output path.
- DWELL=1 advances CH every cycle while in RUN.

## Timing
- Reset (async assert, sampled release):
  - I_Q=0, PENDING=0, DCNT=0, FSM=MANUAL.
  - Outputs: CH=0, ALARM=0, ANY=0, PENDING=0.
  - Asserting reset mid-scan or mid-HOLD discards all pending alarms.
- Latency:
  - I[k] rises before edge E0 -> I_Q[k]=1 after E0 -> PENDING[k]=1 and ANY=1 after E1.
  - ALARM=1 after E1 if CH=k.
  - In RUN, the FSM enters HOLD at E2. CH may advance at E1; if it does, channel k is caught on a later pass.
- ACK latency:
  - ACK high at edge E with I_Q[CH]=0 -> PENDING[CH]=0 and ALARM=0 after E.
  - HOLD exits at E+1 and CH increments at E+1.
- Manual mode: SEL sampled at edge E -> CH valid after E. One cycle of latency.
- Scan period with no pending alarms: each channel is shown for exactly DWELL cycles, and a full cycle is N*DWELL cycles.
- ACK held across several cycles is harmless. It clears each channel it visits, provided that channel's input is low.

## Test plan
Benches use N=8, DWELL=4.
- Reset, then SCAN=1 with I=0 for 64 cycles -> CH steps 0,1,..,7,0 at 4-cycle intervals; ALARM=0, ANY=0 throughout.
- Manual mode: SCAN=0, SEL=5, pulse I[5] for 1 cycle -> PENDING=8'h20 two edges later; ALARM=1 and stays 1 after I[5] falls. ACK=1 for 1 cycle -> PENDING=0, ALARM=0.
- Scan halt:
  - Set I[3]=1 for 1 cycle while scanning -> CH stops at 3 with HOLD, ALARM=1, and CH stays 3 for 20+ cycles.
  - ACK -> CH=4 one edge after PENDING clears.
- Set beats clear: hold I[3]=1 and pulse ACK while in HOLD at CH=3 -> PENDING[3] stays 1 and CH stays 3. Drop I[3], then ACK -> clears and scan resumes at CH=4.
- Wrap and simultaneity:
  - Pulse I[0] and I[7] together while scanning at CH=5 -> halts at 7.
  - ACK -> CH=0, halts at 0. ACK -> resumes at 1.
- Reset mid-HOLD with PENDING=8'h81 -> immediately CH=0, PENDING=0, ALARM=0, ANY=0, FSM=MANUAL.
